inout_sram_banked: RTL and testbench



---
 rtl/inout_sram_pkg.sv | 19 +
 rtl/inout_sram_banked_if.sv | 31 +++
 rtl/rr_arbiter.sv | 42 ++++
 rtl/inout_sram_banked.sv | 168 ++++++++++++++++
 tb/tb_inout_sram_banked.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/inout_sram_pkg.sv
// Shared types and helpers for the banked InOut buffer SRAM.
//   req_op_e   : request opcode carried on req_we (0 = read, 1 = write)
//   idx_w      : index width for an n-entry selection (never below 1 bit)
//   byte_merge : per-byte write-enable merge of old and new data
package inout_sram_pkg;

  typedef enum logic {REQ_RD = 1'b0, REQ_WR = 1'b1} req_op_e;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic logic [7:0] byte_merge(input logic [7:0] old_b,
                                            input logic [7:0] new_b,
                                            input logic       en);
    return en ? new_b : old_b;
  endfunction

endpackage

// File: rtl/inout_sram_banked_if.sv
// Request/response bundle for inout_sram_banked.
//   req_valid/req_ready : per-channel valid/ready handshake
//   req_we/addr/wdata/be: request payload (be ignored on reads)
//   rsp_valid/rsp_rdata : one-cycle response strobe and its data
// master = requester side, slave = memory side.
interface inout_sram_banked_if #(
  parameter int NUM_CH = 2,
  parameter int ADDR_W = 15,
  parameter int DATA_W = 16
);
  localparam int BE_W = DATA_W / 8;

  logic [NUM_CH-1:0]             req_valid;
  logic [NUM_CH-1:0]             req_ready;
  logic [NUM_CH-1:0]             req_we;
  logic [NUM_CH-1:0][ADDR_W-1:0] req_addr;
  logic [NUM_CH-1:0][DATA_W-1:0] req_wdata;
  logic [NUM_CH-1:0][BE_W-1:0]   req_be;
  logic [NUM_CH-1:0]             rsp_valid;
  logic [NUM_CH-1:0][DATA_W-1:0] rsp_rdata;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_be,
    input  req_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_be,
    output req_ready, rsp_valid, rsp_rdata
  );
endinterface

// File: rtl/rr_arbiter.sv
// Round-robin arbiter for one bank.
//   i_req : request vector, one bit per channel
//   i_ptr : channel with highest priority this cycle
//   o_gnt : one-hot grant
//   o_idx : index of the granted channel (valid when o_any)
//   o_any : some channel was granted
module rr_arbiter
  import inout_sram_pkg::*;
#(
  parameter  int N  = 2,
  localparam int IW = idx_w(N)
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_ptr,
  output logic [N-1:0]  o_gnt,
  output logic [IW-1:0] o_idx,
  output logic          o_any
);

  int            w_cand;
  logic [IW-1:0] w_ci;

  // Search upward from the pointer with wrap; the first hit wins.
  always_comb begin
    o_gnt  = '0;
    o_idx  = '0;
    o_any  = 1'b0;
    w_cand = 0;
    w_ci   = '0;
    for (int off = 0; off < N; off++) begin
      w_cand = int'(i_ptr) + off;
      if (w_cand >= N) w_cand = w_cand - N;
      w_ci = IW'(w_cand);
      if (!o_any && i_req[w_ci]) begin
        o_any       = 1'b1;
        o_gnt[w_ci] = 1'b1;
        o_idx       = w_ci;
      end
    end
  end

endmodule

// File: rtl/inout_sram_banked.sv
// Banked, multi-channel behavioural SRAM for the InOut buffer path.
//   clk   : rising-edge clock
//   rst_n : synchronous active-low reset (memory contents are kept)
//   bus   : slave side of inout_sram_banked_if (per-channel requests/responses)
// Words are low-order interleaved over NUM_BANK banks; each bank grants at most
// one channel per cycle by round robin. Writes merge by byte enable and return
// the stored word. Responses arrive RD_LAT (1 or 2) cycles after acceptance.
module inout_sram_banked
  import inout_sram_pkg::*;
#(
  parameter  int ADDR_W   = 15,
  parameter  int DATA_W   = 16,
  parameter  int NUM_BANK = 4,
  parameter  int NUM_CH   = 2,
  parameter  int RD_LAT   = 1,
  localparam int BE_W     = DATA_W / 8
) (
  input logic               clk,
  input logic               rst_n,
  inout_sram_banked_if.slave bus
);

  localparam int BANK_W  = $clog2(NUM_BANK);
  localparam int BANK_IW = idx_w(NUM_BANK);
  localparam int CH_W    = idx_w(NUM_CH);
  localparam int ROW_W   = ADDR_W - BANK_W;
  localparam int DEPTH   = 2 ** ROW_W;

  if (NUM_BANK < 1 || NUM_BANK > 16 || (NUM_BANK & (NUM_BANK - 1)) != 0) begin : g_bad_bank
    $error("inout_sram_banked: NUM_BANK must be a power of two in 1..16");
  end
  if (RD_LAT != 1 && RD_LAT != 2) begin : g_bad_lat
    $error("inout_sram_banked: RD_LAT must be 1 or 2");
  end
  if (DATA_W % 8 != 0) begin : g_bad_dw
    $error("inout_sram_banked: DATA_W must be a multiple of 8");
  end
  if (NUM_CH < 1 || NUM_CH > 4) begin : g_bad_ch
    $error("inout_sram_banked: NUM_CH must be in 1..4");
  end

  logic [NUM_CH-1:0][BANK_IW-1:0]  w_ch_bank;
  logic [NUM_CH-1:0][DATA_W-1:0]   w_ch_rsp;
  logic [NUM_BANK-1:0][NUM_CH-1:0] w_bank_req;
  logic [NUM_BANK-1:0][NUM_CH-1:0] w_gnt_oh;
  logic [NUM_BANK-1:0][CH_W-1:0]   w_gnt_idx;
  logic [NUM_BANK-1:0]             w_gnt_any;
  logic [NUM_BANK-1:0][DATA_W-1:0] w_bank_rsp;
  logic [NUM_CH-1:0]               w_ready;
  logic [NUM_CH-1:0]               w_acc_ch;

  logic [NUM_BANK-1:0][CH_W-1:0]   r_rr_ptr;
  logic [NUM_CH-1:0]               r_s1_valid;
  logic [NUM_CH-1:0][DATA_W-1:0]   r_s1_data;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    if (BANK_W > 0) begin : g_bsel
      assign w_ch_bank[c] = bus.req_addr[c][BANK_W-1:0];
    end else begin : g_bsel0
      assign w_ch_bank[c] = '0;
    end
    assign w_ch_rsp[c] = w_bank_rsp[w_ch_bank[c]];
  end

  // A channel only competes in the bank its address maps to, so OR-ing the
  // per-bank grants gives each channel at most one ready.
  always_comb begin
    w_ready = '0;
    for (int b = 0; b < NUM_BANK; b++) w_ready = w_ready | w_gnt_oh[b];
  end

  assign bus.req_ready = w_ready & {NUM_CH{rst_n}};
  assign w_acc_ch      = bus.req_valid & bus.req_ready;

  for (genvar b = 0; b < NUM_BANK; b++) begin : g_bank
    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [CH_W-1:0]   w_sel;
    logic [ROW_W-1:0]  w_row;
    logic [DATA_W-1:0] w_old;
    logic [DATA_W-1:0] w_merged;
    logic              w_is_wr;
    logic              w_wr;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_req
      assign w_bank_req[b][c] = bus.req_valid[c] & (w_ch_bank[c] == BANK_IW'(b));
    end

    rr_arbiter #(.N(NUM_CH)) u_arb (
      .i_req (w_bank_req[b]),
      .i_ptr (r_rr_ptr[b]),
      .o_gnt (w_gnt_oh[b]),
      .o_idx (w_gnt_idx[b]),
      .o_any (w_gnt_any[b])
    );

    assign w_sel   = w_gnt_idx[b];
    assign w_row   = ROW_W'(bus.req_addr[w_sel] >> BANK_W);
    assign w_old   = r_mem[w_row];
    assign w_is_wr = (req_op_e'(bus.req_we[w_sel]) == REQ_WR);
    assign w_wr    = w_gnt_any[b] & rst_n & w_is_wr;

    always_comb begin
      w_merged = w_old;
      for (int i = 0; i < BE_W; i++) begin
        w_merged[8*i +: 8] = byte_merge(w_old[8*i +: 8],
                                        bus.req_wdata[w_sel][8*i +: 8],
                                        bus.req_be[w_sel][i]);
      end
    end

    // Reads see the pre-edge word; writes echo the merged word.
    assign w_bank_rsp[b] = w_is_wr ? w_merged : w_old;

    always_ff @(posedge clk) begin
      if (w_wr) r_mem[w_row] <= w_merged;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rr_ptr <= '0;
    end else begin
      for (int b = 0; b < NUM_BANK; b++) begin
        if (w_gnt_any[b]) begin
          r_rr_ptr[b] <= (w_gnt_idx[b] == CH_W'(NUM_CH - 1)) ? '0
                                                               : w_gnt_idx[b] + CH_W'(1);
        end
      end
    end
  end

  // Data registers load only with a response so rsp_rdata holds between them.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s1_valid <= '0;
      r_s1_data  <= '0;
    end else begin
      r_s1_valid <= w_acc_ch;
      for (int c = 0; c < NUM_CH; c++) begin
        if (w_acc_ch[c]) r_s1_data[c] <= w_ch_rsp[c];
      end
    end
  end

  if (RD_LAT == 2) begin : g_lat2
    logic [NUM_CH-1:0]             r_s2_valid;
    logic [NUM_CH-1:0][DATA_W-1:0] r_s2_data;

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        r_s2_valid <= '0;
        r_s2_data  <= '0;
      end else begin
        r_s2_valid <= r_s1_valid;
        for (int c = 0; c < NUM_CH; c++) begin
          if (r_s1_valid[c]) r_s2_data[c] <= r_s1_data[c];
        end
      end
    end

    assign bus.rsp_valid = r_s2_valid;
    assign bus.rsp_rdata = r_s2_data;
  end else begin : g_lat1
    assign bus.rsp_valid = r_s1_valid;
    assign bus.rsp_rdata = r_s1_data;
  end

endmodule

// File: tb/tb_inout_sram_banked.sv
module tb_inout_sram_banked;

  logic clk;
  logic rst_n;
  logic sel;

  logic [1:0]       d_valid;
  logic [1:0]       d_we;
  logic [1:0][14:0] d_addr;
  logic [1:0][15:0] d_wdata;
  logic [1:0][1:0]  d_be;

  logic [1:0]       o_rdy;
  logic [1:0]       o_rv;
  logic [1:0][15:0] o_rd;

  int n_checks;
  int n_errors;

  inout_sram_banked_if #(.NUM_CH(2), .ADDR_W(15), .DATA_W(16)) if1 ();
  inout_sram_banked_if #(.NUM_CH(2), .ADDR_W(15), .DATA_W(16)) if2 ();

  inout_sram_banked #(.ADDR_W(15), .DATA_W(16), .NUM_BANK(4), .NUM_CH(2), .RD_LAT(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .bus(if1)
  );
  inout_sram_banked #(.ADDR_W(15), .DATA_W(16), .NUM_BANK(4), .NUM_CH(2), .RD_LAT(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .bus(if2)
  );

  assign if1.req_valid = sel ? 2'b00 : d_valid;
  assign if2.req_valid = sel ? d_valid : 2'b00;
  assign if1.req_we    = d_we;
  assign if2.req_we    = d_we;
  assign if1.req_addr  = d_addr;
  assign if2.req_addr  = d_addr;
  assign if1.req_wdata = d_wdata;
  assign if2.req_wdata = d_wdata;
  assign if1.req_be    = d_be;
  assign if2.req_be    = d_be;

  assign o_rdy = sel ? if2.req_ready : if1.req_ready;
  assign o_rv  = sel ? if2.rsp_valid : if1.rsp_valid;
  assign o_rd  = sel ? if2.rsp_rdata : if1.rsp_rdata;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  valid;
    logic [1:0]  we;
    logic [14:0] a0;
    logic [15:0] w0;
    logic [1:0]  be0;
    logic [14:0] a1;
    logic [15:0] w1;
    logic [1:0]  be1;
    logic [1:0]  e_rdy;
    logic [1:0]  e_rv;
    logic [15:0] e_d0;
    logic [15:0] e_d1;
  } vec_t;

  vec_t tbl [19];

  function automatic vec_t mk(input logic [1:0] v, input logic [1:0] we,
                              input logic [14:0] a0, input logic [15:0] w0, input logic [1:0] be0,
                              input logic [14:0] a1, input logic [15:0] w1, input logic [1:0] be1,
                              input logic [1:0] e_rdy, input logic [1:0] e_rv,
                              input logic [15:0] e_d0, input logic [15:0] e_d1);
    vec_t t;
    t.valid = v;  t.we = we;
    t.a0 = a0;    t.w0 = w0;  t.be0 = be0;
    t.a1 = a1;    t.w1 = w1;  t.be1 = be1;
    t.e_rdy = e_rdy; t.e_rv = e_rv; t.e_d0 = e_d0; t.e_d1 = e_d1;
    return t;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [1:0] v, input logic [1:0] we,
                       input logic [14:0] a0, input logic [15:0] w0, input logic [1:0] be0,
                       input logic [14:0] a1, input logic [15:0] w1, input logic [1:0] be1);
    @(posedge clk);
    #1;
    d_valid = v;
    d_we    = we;
    d_addr[0] = a0;  d_wdata[0] = w0;  d_be[0] = be0;
    d_addr[1] = a1;  d_wdata[1] = w1;  d_be[1] = be1;
  endtask

  task automatic idle();
    drive(2'b00, 2'b00, 15'h0, 16'h0, 2'b00, 15'h0, 16'h0, 2'b00);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        exp_v;
    logic [15:0] exp_d;
    n_checks = 0;
    n_errors = 0;
    sel     = 1'b0;
    rst_n   = 1'b0;
    d_valid = 2'b11;
    d_we    = 2'b00;
    d_addr  = '0;
    d_wdata = '0;
    d_be    = '0;

    //            valid  we     a0       w0        be0    a1       w1        be1    rdy    rv     d0        d1
    tbl[0]  = mk(2'b01, 2'b01, 15'h0005, 16'hA5C3, 2'b11, 15'h0000, 16'h0000, 2'b00, 2'b01, 2'b00, 16'h0000, 16'h0000);
    tbl[1]  = mk(2'b01, 2'b00, 15'h0005, 16'h0000, 2'b00, 15'h0000, 16'h0000, 2'b00, 2'b01, 2'b01, 16'hA5C3, 16'h0000);
    tbl[2]  = mk(2'b01, 2'b01, 15'h0010, 16'h1234, 2'b11, 15'h0000, 16'h0000, 2'b00, 2'b01, 2'b01, 16'hA5C3, 16'h0000);
    tbl[3]  = mk(2'b10, 2'b10, 15'h0000, 16'h0000, 2'b00, 15'h0010, 16'hFFFF, 2'b01, 2'b10, 2'b01, 16'h1234, 16'h0000);
    tbl[4]  = mk(2'b10, 2'b00, 15'h0000, 16'h0000, 2'b00, 15'h0010, 16'h0000, 2'b00, 2'b10, 2'b10, 16'h1234, 16'h12FF);
    tbl[5]  = mk(2'b01, 2'b01, 15'h0000, 16'h1111, 2'b11, 15'h0000, 16'h0000, 2'b00, 2'b01, 2'b10, 16'h1234, 16'h12FF);
    tbl[6]  = mk(2'b10, 2'b10, 15'h0000, 16'h0000, 2'b00, 15'h0004, 16'h2222, 2'b11, 2'b10, 2'b01, 16'h1111, 16'h12FF);
    tbl[7]  = mk(2'b11, 2'b00, 15'h0000, 16'h0000, 2'b00, 15'h0004, 16'h0000, 2'b00, 2'b01, 2'b10, 16'h1111, 16'h2222);
    tbl[8]  = mk(2'b11, 2'b00, 15'h0000, 16'h0000, 2'b00, 15'h0004, 16'h0000, 2'b00, 2'b10, 2'b01, 16'h1111, 16'h2222);
    tbl[9]  = mk(2'b11, 2'b00, 15'h0000, 16'h0000, 2'b00, 15'h0004, 16'h0000, 2'b00, 2'b01, 2'b10, 16'h1111, 16'h2222);
    tbl[10] = mk(2'b11, 2'b00, 15'h0000, 16'h0000, 2'b00, 15'h0004, 16'h0000, 2'b00, 2'b10, 2'b01, 16'h1111, 16'h2222);
    tbl[11] = mk(2'b11, 2'b10, 15'h0000, 16'h0000, 2'b00, 15'h0001, 16'hBEEF, 2'b11, 2'b11, 2'b10, 16'h1111, 16'h2222);
    tbl[12] = mk(2'b11, 2'b00, 15'h0000, 16'h0000, 2'b00, 15'h0001, 16'h0000, 2'b00, 2'b11, 2'b11, 16'h1111, 16'hBEEF);
    tbl[13] = mk(2'b00, 2'b00, 15'h0000, 16'h0000, 2'b00, 15'h0000, 16'h0000, 2'b00, 2'b00, 2'b11, 16'h1111, 16'hBEEF);
    tbl[14] = mk(2'b00, 2'b00, 15'h0000, 16'h0000, 2'b00, 15'h0000, 16'h0000, 2'b00, 2'b00, 2'b00, 16'h1111, 16'hBEEF);
    tbl[15] = mk(2'b11, 2'b11, 15'h7FFF, 16'hCAFE, 2'b11, 15'h0000, 16'h0F0F, 2'b11, 2'b11, 2'b00, 16'h1111, 16'hBEEF);
    tbl[16] = mk(2'b11, 2'b00, 15'h0000, 16'h0000, 2'b00, 15'h7FFF, 16'h0000, 2'b00, 2'b11, 2'b11, 16'hCAFE, 16'h0F0F);
    tbl[17] = mk(2'b01, 2'b01, 15'h0005, 16'h0000, 2'b00, 15'h0000, 16'h0000, 2'b00, 2'b01, 2'b11, 16'h0F0F, 16'hCAFE);
    tbl[18] = mk(2'b00, 2'b00, 15'h0000, 16'h0000, 2'b00, 15'h0000, 16'h0000, 2'b00, 2'b00, 2'b01, 16'hA5C3, 16'hCAFE);

    // Reset: requests presented while rst_n is low must not be granted.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("reset%0d ready", i), 32'(o_rdy), 32'h0);
      chk($sformatf("reset%0d rsp_valid", i), 32'(o_rv), 32'h0);
      chk($sformatf("reset%0d rdata0", i), 32'(o_rd[0]), 32'h0);
      chk($sformatf("reset%0d rdata1", i), 32'(o_rd[1]), 32'h0);
    end
    @(posedge clk);
    #1;
    rst_n   = 1'b1;
    d_valid = 2'b00;
    @(negedge clk);

    // RD_LAT=1 instance: one row per cycle.
    for (int i = 0; i < 19; i++) begin
      drive(tbl[i].valid, tbl[i].we, tbl[i].a0, tbl[i].w0, tbl[i].be0,
            tbl[i].a1, tbl[i].w1, tbl[i].be1);
      @(negedge clk);
      chk($sformatf("row%0d ready", i), 32'(o_rdy), 32'(tbl[i].e_rdy));
      chk($sformatf("row%0d rsp_valid", i), 32'(o_rv), 32'(tbl[i].e_rv));
      chk($sformatf("row%0d rdata0", i), 32'(o_rd[0]), 32'(tbl[i].e_d0));
      chk($sformatf("row%0d rdata1", i), 32'(o_rd[1]), 32'(tbl[i].e_d1));
    end

    // RD_LAT=2 instance: preload 0x0100..0x0107, then stream reads.
    sel = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive(2'b01, 2'b01, 15'(32'h100 + i), 16'(32'h5000 + i), 2'b11, 15'h0, 16'h0, 2'b00);
      @(negedge clk);
      chk($sformatf("lat2 wr%0d ready", i), 32'(o_rdy), 32'h1);
    end
    idle();
    idle();
    idle();
    for (int cyc = 0; cyc < 12; cyc++) begin
      if (cyc < 8) drive(2'b01, 2'b00, 15'(32'h100 + cyc), 16'h0, 2'b00, 15'h0, 16'h0, 2'b00);
      else         idle();
      @(negedge clk);
      if (cyc < 8) chk($sformatf("lat2 rd%0d ready", cyc), 32'(o_rdy), 32'h1);
      exp_v = (cyc >= 2 && cyc < 10);
      if (cyc >= 2 && cyc < 10) exp_d = 16'(32'h5000 + cyc - 2);
      else                      exp_d = 16'h5007;
      chk($sformatf("lat2 cyc%0d rsp_valid", cyc), 32'(o_rv), {30'h0, 1'b0, exp_v});
      chk($sformatf("lat2 cyc%0d rdata0", cyc), 32'(o_rd[0]), 32'(exp_d));
    end

    // Reset one cycle after a read accept on the RD_LAT=2 instance.
    drive(2'b01, 2'b01, 15'h0200, 16'h7777, 2'b11, 15'h0, 16'h0, 2'b00);
    @(negedge clk);
    chk("rst_mid wr ready", 32'(o_rdy), 32'h1);
    idle();
    idle();
    drive(2'b01, 2'b00, 15'h0200, 16'h0, 2'b00, 15'h0, 16'h0, 2'b00);
    @(negedge clk);
    chk("rst_mid rd ready", 32'(o_rdy), 32'h1);
    drive(2'b11, 2'b01, 15'h0200, 16'h9999, 2'b11, 15'h0200, 16'h0, 2'b00);
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst_mid r0 ready", 32'(o_rdy), 32'h0);
    chk("rst_mid r0 rsp_valid", 32'(o_rv), 32'h0);
    drive(2'b11, 2'b01, 15'h0200, 16'h9999, 2'b11, 15'h0200, 16'h0, 2'b00);
    @(negedge clk);
    chk("rst_mid r1 ready", 32'(o_rdy), 32'h0);
    chk("rst_mid r1 rsp_valid", 32'(o_rv), 32'h0);
    chk("rst_mid r1 rdata0", 32'(o_rd[0]), 32'h0);
    drive(2'b11, 2'b00, 15'h0200, 16'h0, 2'b00, 15'h0200, 16'h0, 2'b00);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst ptr ready", 32'(o_rdy), 32'h1);
    chk("post_rst rsp_valid a", 32'(o_rv), 32'h0);
    drive(2'b10, 2'b00, 15'h0, 16'h0, 2'b00, 15'h0200, 16'h0, 2'b00);
    @(negedge clk);
    chk("post_rst ch1 ready", 32'(o_rdy), 32'h2);
    chk("post_rst rsp_valid b", 32'(o_rv), 32'h0);
    idle();
    @(negedge clk);
    chk("post_rst rsp_valid c", 32'(o_rv), 32'h1);
    chk("post_rst rdata0", 32'(o_rd[0]), 32'h7777);
    idle();
    @(negedge clk);
    chk("post_rst rsp_valid d", 32'(o_rv), 32'h2);
    chk("post_rst rdata1", 32'(o_rd[1]), 32'h7777);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
